// File: rtl/promedio_sched.sv
// -----------------------------------------------------------------------------
// promedio_sched
//
// Round-robin scheduler that time-shares one external 4-sample averager
// ("promedio") among NCH sample channels.
//
// Operation: a pending channel is granted and its sample is steered onto the
// averager input. The scheduler then sequences the averager's sum_en, captures
// the averaged result, and hands it to the consumer over a valid/ready
// handshake tagged with the channel ID. When the handshake completes, the
// granted channel receives a one-cycle ack pulse.
//
// Optional build macro: PROM_SCHED_TIMEOUT_EN
//   Defined   : adds output err and a 4-bit ACCUM watchdog. If avg_sum_ready
//               has not arrived by 10 cycles after ACCUM entry, the scheduler
//               pulses err, aborts the transfer without an ack, and returns
//               to IDLE.
//   Undefined : ACCUM waits for avg_sum_ready indefinitely.
//
// Ports
//   clk            single clock, all state updates on posedge
//   reset_n        asynchronous active-low reset
//   en             global enable; low aborts any transfer and idles
//   req[NCH]       level request per channel, held until ack
//   sample[N*NCH]  channel samples, channel i at [i*N +: N]
//   ack[NCH]       one-cycle pulse to the served channel on result handshake
//   avg_en         averager en (en delayed one cycle)
//   avg_sum_en     averager sum_en (high only while accumulating)
//   avg_in[N]      averager input, combinational mux of the granted sample
//   avg_sum_ready  averager sum_ready
//   avg_out[N-2]   averager result
//   res_valid      result valid
//   res_ready      consumer ready
//   res_data[N-2]  captured average
//   res_ch[CHW]    channel ID of res_data
//   busy           scheduler is not idle
//   err            (timeout build only) one-cycle watchdog expiry pulse
// -----------------------------------------------------------------------------
module promedio_sched #(
    parameter int N   = 8,
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [NCH-1:0]     req,
    input  logic [N*NCH-1:0]   sample,
    output logic [NCH-1:0]     ack,
    output logic               avg_en,
    output logic               avg_sum_en,
    output logic [N-1:0]       avg_in,
    input  logic               avg_sum_ready,
    input  logic [N-3:0]       avg_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N-3:0]       res_data,
    output logic [CHW-1:0]     res_ch,
    output logic               busy
`ifdef PROM_SCHED_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t             state_r;
    logic [CHW-1:0]     sel_r;
    logic [CHW-1:0]     ptr_r;
    logic [NCH-1:0]     ack_r;
    logic               avg_en_r;
    logic               avg_sum_en_r;
    logic               res_valid_r;
    logic [N-3:0]       res_data_r;
    logic [CHW-1:0]     res_ch_r;

    logic               grant_found_s;
    logic [CHW-1:0]     grant_idx_s;
    logic [N-1:0]       sample_arr_s [NCH];

`ifdef PROM_SCHED_TIMEOUT_EN
    logic [3:0]         tmo_cnt_r;
    logic               err_r;
`endif

    // Round-robin pick: the first set request bit at or after (p+1) mod NCH.
    // The offsets are scanned from farthest to nearest so that the nearest
    // hit is the one left in the result. Returns {found, index}.
    function automatic logic [CHW:0] rr_pick(input logic [NCH-1:0] r,
                                             input logic [CHW-1:0] p);
        logic [CHW:0] res;
        int           idx;
        res = {(CHW+1){1'b0}};
        for (int i = NCH; i >= 1; i--) begin
            idx = int'(p) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end else begin
                idx = idx;
            end
            if (r[idx]) begin
                res = {1'b1, idx[CHW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration result for the current request vector and pointer.
    assign {grant_found_s, grant_idx_s} = rr_pick(req, ptr_r);

    // Split the flat sample bus into per-channel words.
    for (genvar g = 0; g < NCH; g++) begin : g_split
        assign sample_arr_s[g] = sample[g*N +: N];
    end

    // sel only changes on a grant, so the averager sees one steady sample
    // for the whole transfer.
    assign avg_in = sample_arr_s[sel_r];

    // Registered outputs.
    assign ack        = ack_r;
    assign avg_en     = avg_en_r;
    assign avg_sum_en = avg_sum_en_r;
    assign res_valid  = res_valid_r;
    assign res_data   = res_data_r;
    assign res_ch     = res_ch_r;
    assign busy       = (state_r != ST_IDLE);
`ifdef PROM_SCHED_TIMEOUT_EN
    assign err        = err_r;
`endif

    // Scheduler FSM together with all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= {CHW{1'b0}};
            ptr_r        <= CHW'(NCH - 1);
            ack_r        <= {NCH{1'b0}};
            avg_en_r     <= 1'b0;
            avg_sum_en_r <= 1'b0;
            res_valid_r  <= 1'b0;
            res_data_r   <= {(N-2){1'b0}};
            res_ch_r     <= {CHW{1'b0}};
`ifdef PROM_SCHED_TIMEOUT_EN
            tmo_cnt_r    <= 4'd0;
            err_r        <= 1'b0;
`endif
        end else begin
            avg_en_r <= en;
            // ack and err are single-cycle pulses, cleared unless re-asserted.
            ack_r    <= {NCH{1'b0}};
`ifdef PROM_SCHED_TIMEOUT_EN
            err_r    <= 1'b0;
`endif
            if (!en) begin
                // Abort: the channel keeps its request and is re-arbitrated
                // once en returns.
                state_r      <= ST_IDLE;
                avg_sum_en_r <= 1'b0;
                res_valid_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (grant_found_s) begin
                            sel_r        <= grant_idx_s;
                            ptr_r        <= grant_idx_s;
                            avg_sum_en_r <= 1'b1;
                            state_r      <= ST_ACCUM;
`ifdef PROM_SCHED_TIMEOUT_EN
                            tmo_cnt_r    <= 4'd0;
`endif
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ACCUM: begin
                        if (avg_sum_ready) begin
                            avg_sum_en_r <= 1'b0;
                            state_r      <= ST_CAPTURE;
`ifdef PROM_SCHED_TIMEOUT_EN
                        end else if (tmo_cnt_r == 4'd9) begin
                            // Tenth ACCUM cycle with no result: abandon the
                            // transfer. ptr already points at this channel,
                            // so other requesters are served first.
                            err_r        <= 1'b1;
                            avg_sum_en_r <= 1'b0;
                            state_r      <= ST_IDLE;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + 4'd1;
`else
                        end else begin
                            state_r <= ST_ACCUM;
`endif
                        end
                    end
                    ST_CAPTURE: begin
                        // The averager drives the finished average this cycle.
                        res_data_r  <= avg_out;
                        res_ch_r    <= sel_r;
                        res_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (res_ready) begin
                            res_valid_r <= 1'b0;
                            ack_r       <= {{(NCH-1){1'b0}}, 1'b1} << sel_r;
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end
                    default: begin
                        avg_sum_en_r <= 1'b0;
                        res_valid_r  <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_promedio_sched.sv
// -----------------------------------------------------------------------------
// tb_promedio_sched
//
// Directed testbench for promedio_sched with NCH=4 and N=8. It includes a
// behavioural model of the 4-sample averager. Expected results are queued
// when a request is issued and checked when res_valid appears.
// -----------------------------------------------------------------------------
module tb_promedio_sched;

    localparam int N   = 8;
    localparam int NCH = 4;
    localparam int CHW = 2;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [N-3:0]   data;
    } exp_t;

    logic               clk;
    logic               reset_n;
    logic               en;
    logic [NCH-1:0]     req;
    logic [N*NCH-1:0]   sample;
    logic [NCH-1:0]     ack;
    logic               avg_en;
    logic               avg_sum_en;
    logic [N-1:0]       avg_in;
    logic               avg_sum_ready;
    logic [N-3:0]       avg_out;
    logic               res_valid;
    logic               res_ready;
    logic [N-3:0]       res_data;
    logic [CHW-1:0]     res_ch;
    logic               busy;
`ifdef PROM_SCHED_TIMEOUT_EN
    logic               err;
`endif

    // Averager model state.
    logic [N-1:0]       m_sum;
    logic [2:0]         m_cnt;
    logic               m_ready;
    logic [N-3:0]       m_out;
    logic               force_no_ready;

    int                 n_cmp;
    int                 n_fail;
    exp_t               sb[$];

    promedio_sched #(.N(N), .NCH(NCH), .CHW(CHW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .req           (req),
        .sample        (sample),
        .ack           (ack),
        .avg_en        (avg_en),
        .avg_sum_en    (avg_sum_en),
        .avg_in        (avg_in),
        .avg_sum_ready (avg_sum_ready),
        .avg_out       (avg_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_ch        (res_ch),
        .busy          (busy)
`ifdef PROM_SCHED_TIMEOUT_EN
        ,
        .err           (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Averager model: synchronous reset. It adds four samples on the four
    // edges after sum_en rises, then publishes sum[N-1:2] and sum_ready one
    // edge later. It clears whenever sum_en is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_sum   <= '0;
            m_cnt   <= 3'd0;
            m_ready <= 1'b0;
            m_out   <= '0;
        end else if (!avg_sum_en) begin
            m_sum   <= '0;
            m_cnt   <= 3'd0;
            m_ready <= 1'b0;
        end else if (avg_en) begin
            if (m_cnt < 3'd4) begin
                m_sum <= m_sum + avg_in;
                m_cnt <= m_cnt + 3'd1;
            end else if (m_cnt == 3'd4) begin
                m_out   <= m_sum[N-1:2];
                m_ready <= 1'b1;
                m_cnt   <= 3'd5;
            end
        end
    end

    assign avg_sum_ready = m_ready & ~force_no_ready;
    assign avg_out       = m_out;

    // Wrapping four-sample average of a constant sample.
    function automatic logic [N-3:0] exp_avg(input logic [N-1:0] s);
        logic [N+1:0] sum4;
        sum4 = {2'b00, s} * 10'd4;
        return sum4[N-1:2];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [N-1:0] s);
        exp_t e;
        e.ch   = CHW'(ch);
        e.data = exp_avg(s);
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the first negedge with res_valid high.
    task automatic wait_valid();
        int cycles;
        cycles = 0;
        while (!res_valid && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        chk("valid_timeout", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic pop_check(output exp_t e);
        chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
        e = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_ch", res_ch, e.ch);
            chk("res_data", res_data, e.data);
        end
    endtask

    // Wait for the next result, check it, complete the handshake (res_ready
    // is already high), check the ack pulse, and drop that channel's request.
    task automatic serve();
        exp_t e;
        wait_valid();
        pop_check(e);
        @(negedge clk);
        chk("ack_pulse", ack, NCH'(1) << e.ch);
        chk("valid_clear", res_valid, 0);
        req[e.ch] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        exp_t e;
        n_cmp = 0;
        n_fail = 0;
        reset_n = 1'b0;
        en = 1'b0;
        req = '0;
        sample = '0;
        res_ready = 1'b0;
        force_no_ready = 1'b0;
        sample[0*N +: N] = 8'd40;
        sample[1*N +: N] = 8'd100;
        sample[2*N +: N] = 8'd7;
        sample[3*N +: N] = 8'd200;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sum_en", avg_sum_en, 0);
        chk("rst_avg_en", avg_en, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_ack", ack, 0);
        chk("rst_data", res_data, 0);
        chk("rst_ch", res_ch, 0);
        reset_n = 1'b1;
        en = 1'b1;
        @(negedge clk);
        chk("avg_en_follow", avg_en, 1);
        chk("idle_busy", busy, 0);

        // Single channel: latency, result, backpressure, and ack.
        push(0, 8'd40);
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        chk("grant_busy", busy, 1);
        chk("grant_sum_en", avg_sum_en, 1);
        chk("grant_avg_in", avg_in, 40);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (res_valid && lat == 0) lat = k;
        end
        chk("latency", lat, 7);
        pop_check(e);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, e.data);
            chk("bp_ch", res_ch, e.ch);
            chk("bp_ack", ack, 0);
            chk("bp_sum_en", avg_sum_en, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("single_ack", ack, 4'b0001);
        chk("single_valid", res_valid, 0);
        chk("single_idle", busy, 0);
        req = 4'b0000;
        @(negedge clk);
        chk("single_ack_once", ack, 0);

        // Asynchronous reset in the middle of ACCUM.
        req = 4'b0100;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_sum_en", avg_sum_en, 1);
        chk("mid_avg_in", avg_in, 7);
        #2 reset_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_sum_en", avg_sum_en, 0);
        chk("async_avg_en", avg_en, 0);
        chk("async_valid", res_valid, 0);
        chk("async_ack", ack, 0);
        req = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_sum_en", avg_sum_en, 0);

        // Round-robin: all channels requesting from a reset pointer.
        push(0, 8'd40);
        push(1, 8'd100);
        push(2, 8'd7);
        push(3, 8'd200);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) serve();
        push(0, 8'd40);
        push(2, 8'd7);
        req = 4'b0101;
        serve();
        serve();

        // en dropped mid-ACCUM: idle next edge, no ack, channel stays pending.
        req = 4'b0010;
        repeat (2) @(negedge clk);
        chk("en_pre_busy", busy, 1);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_busy", busy, 0);
        chk("en_off_sum_en", avg_sum_en, 0);
        chk("en_off_valid", res_valid, 0);
        chk("en_off_ack", ack, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_off_hold_ack", ack, 0);
            chk("en_off_hold_busy", busy, 0);
        end
        en = 1'b1;
        push(1, 8'd100);
        serve();

`ifdef PROM_SCHED_TIMEOUT_EN
        // Watchdog: sum_ready suppressed, so err fires 10 edges after grant.
        force_no_ready = 1'b1;
        req = 4'b0001;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (err && lat == 0) begin
                lat = k;
                chk("tmo_busy", busy, 0);
                chk("tmo_ack", ack, 0);
                chk("tmo_sum_en", avg_sum_en, 0);
                force_no_ready = 1'b0;
                break;
            end
        end
        chk("tmo_latency", lat, 10);
        @(negedge clk);
        chk("tmo_err_pulse", err, 0);
        chk("tmo_regrant", busy, 1);
        push(0, 8'd40);
        serve();
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
